// File: rtl/rhd_spi_sequencer.sv
// SPI master for one RHD conversion frame across eight headstage ports.
// Drives the shared CS/SCLK/MOSI bus and captures eight MISO lines into 16-bit words.
module rhd_spi_sequencer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned NUM_CMDS   = 35,
  parameter int unsigned CS_HIGH    = 4,
  parameter int unsigned MISO_DELAY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         continuous,
  output logic         busy,
  output logic         frame_done,
  output logic         CS,
  output logic         SCLK,
  output logic         MOSI,
  input  logic [7:0]   miso,
  output logic         word_valid,
  output logic [5:0]   word_index,
  output logic [127:0] word_data
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned HOLD_W = $clog2(CS_HIGH);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH - 1);
  localparam logic [5:0]        IDX_LAST  = 6'(NUM_CMDS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HI} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [4:0]        half_cnt, half_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [5:0]        cmd_idx, idx_nxt;
  logic [15:0]       cmd_nxt;
  logic              cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;

  logic              strobe_c, strobe_d;
  logic [3:0]        bit_cnt;
  logic [127:0]      sr, sr_shift_c;

  // CONVERT(i) for the first 32 commands, READ(40+i-32) afterwards
  function automatic logic [15:0] cmd_word(input logic [5:0] idx);
    if (idx < 6'd32) cmd_word = {2'b00, idx, 8'h00};
    else             cmd_word = {2'b11, 6'(idx + 6'd8), 8'h00};
  endfunction

  // Next-state and next-output logic; outputs are registered from the next-state view
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    half_nxt  = half_cnt;
    hold_nxt  = hold_cnt;
    idx_nxt   = cmd_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          half_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (half_cnt == 5'd31) begin
            state_nxt = CS_HI;
            hold_nxt  = '0;
          end else begin
            half_nxt = half_cnt + 5'd1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      CS_HI: begin
        if (hold_cnt == HOLD_LAST) begin
          div_nxt  = '0;
          half_nxt = '0;
          if (cmd_idx != IDX_LAST) begin
            idx_nxt   = cmd_idx + 6'd1;
            state_nxt = SHIFT;
          end else begin
            idx_nxt   = '0;
            state_nxt = continuous ? SHIFT : IDLE;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    cmd_nxt  = cmd_word(idx_nxt);
    cs_nxt   = (state_nxt != SHIFT);
    sclk_nxt = (state_nxt == SHIFT) && half_nxt[0];
    mosi_nxt = (state_nxt == SHIFT) && cmd_nxt[4'd15 - half_nxt[4:1]];
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == CS_HI) && (hold_nxt == HOLD_LAST) && (idx_nxt == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      half_cnt   <= '0;
      hold_cnt   <= '0;
      cmd_idx    <= '0;
      CS         <= 1'b1;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      half_cnt   <= half_nxt;
      hold_cnt   <= hold_nxt;
      cmd_idx    <= idx_nxt;
      CS         <= cs_nxt;
      SCLK       <= sclk_nxt;
      MOSI       <= mosi_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Sample point: last clk of each SCLK-high half-period, optionally delayed for cable skew
  assign strobe_c = (state == SHIFT) && half_cnt[0] && (div_cnt == DIV_LAST);

  generate
    if (MISO_DELAY == 0) begin : g_no_dly
      assign strobe_d = strobe_c;
    end else begin : g_dly
      logic [MISO_DELAY-1:0] pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= MISO_DELAY'({pipe, strobe_c});
      end
      assign strobe_d = pipe[MISO_DELAY-1];
    end
  endgenerate

  always_comb begin
    sr_shift_c = '0;
    for (int k = 0; k < 8; k++) begin
      sr_shift_c[16*k +: 16] = {sr[16*k +: 15], miso[k]};
    end
  end

  // Capture: the 16th strobe completes a word, published one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      word_index <= '0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (strobe_d) begin
        sr      <= sr_shift_c;
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          word_valid <= 1'b1;
          word_index <= cmd_idx;
          word_data  <= sr_shift_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhd_spi_sequencer.sv
// Directed bench for rhd_spi_sequencer: framing, MOSI content, loopback capture,
// continuous mode and mid-command reset.
module tb_rhd_spi_sequencer;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic start      = 1'b0;
  logic continuous = 1'b0;

  logic         busy, frame_done, cs, sclk, mosi, word_valid;
  logic [5:0]   widx;
  logic [127:0] wdata;
  logic [7:0]   miso0;

  logic         busy1, frame_done1, cs1, sclk1, mosi1, wv1;
  logic [5:0]   widx1;
  logic [127:0] wdata1;
  logic [7:0]   miso1;
  logic         mosi1_d = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  bit          cs_q = 1'b1, sclk_q = 1'b0, have_win = 1'b0;
  int          win_len = 0, win_rise = 0, gap = 0;
  logic [15:0] dec = '0;
  int          n_win = 0, n_wv = 0, n_fd = 0, busy_cyc = 0, exp_idx = 0, n_wv1 = 0;

  always #5 clk = ~clk;

  assign miso0 = {8{mosi}};
  assign miso1 = {8{mosi1_d}};
  always @(posedge clk) mosi1_d <= mosi1;

  rhd_spi_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done), .CS(cs), .SCLK(sclk), .MOSI(mosi),
    .miso(miso0), .word_valid(word_valid), .word_index(widx), .word_data(wdata)
  );

  rhd_spi_sequencer #(.MISO_DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(1'b0),
    .busy(busy1), .frame_done(frame_done1), .CS(cs1), .SCLK(sclk1), .MOSI(mosi1),
    .miso(miso1), .word_valid(wv1), .word_index(widx1), .word_data(wdata1)
  );

  function automatic logic [15:0] cmd_model(input int i);
    if (i < 32) return 16'(i * 256);
    return 16'hC000 | 16'((i + 8) * 256);
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: CS windows, SCLK edges, decoded MOSI, CS gaps, captured words
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_q = 1'b1; sclk_q = 1'b0; have_win = 1'b0; gap = 0;
    end else begin
      if (!cs) begin
        if (cs_q) begin
          if (have_win) check("cs_gap", 128'(gap), 128'(4));
          win_len = 0; win_rise = 0; dec = '0; gap = 0;
        end
        win_len++;
        if (sclk && !sclk_q) begin
          win_rise++;
          dec = {dec[14:0], mosi};
        end
      end else begin
        if (!cs_q) begin
          check("win_len", 128'(win_len), 128'(64));
          check("win_sclk", 128'(win_rise), 128'(16));
          check($sformatf("mosi_cmd%0d", n_win % 35), 128'(dec), 128'(cmd_model(n_win % 35)));
          n_win++;
          have_win = 1'b1;
        end
        if (busy) gap++;
      end
      if (!busy) have_win = 1'b0;
      if (busy) busy_cyc++;
      if (frame_done) n_fd++;
      if (word_valid) begin
        check("wv_index", 128'(widx), 128'(exp_idx));
        check("wv_cs", 128'(cs), 128'(1));
        check("loop0_data", wdata, {8{cmd_model(int'(widx))}});
        exp_idx = (exp_idx + 1) % 35;
        n_wv++;
      end
      if (wv1) begin
        check("loop1_data", wdata1, {8{cmd_model(int'(widx1))}});
        n_wv1++;
      end
      cs_q = cs;
      sclk_q = sclk;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int limit);
    int n = 0;
    while (frame_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("fd_wait", 128'(frame_done), 128'(1));
  endtask

  initial begin
    int n;
    // Reset held with start high: bus must stay idle
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_cs", 128'(cs), 128'(1));
      check("rst_sclk", 128'(sclk), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_wv", 128'(word_valid), 128'(0));
    end
    check("rst_mosi", 128'(mosi), 128'(0));
    check("rst_fd", 128'(frame_done), 128'(0));
    check("rst_widx", 128'(widx), 128'(0));
    check("rst_wdata", wdata, 128'(0));
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cs", 128'(cs), 128'(1));

    // Single frame
    n_win = 0; n_wv = 0; n_fd = 0; busy_cyc = 0; exp_idx = 0; n_wv1 = 0;
    pulse_start();
    check("cs_fall", 128'(cs), 128'(0));
    check("busy_rise", 128'(busy), 128'(1));
    wait_fd(3000);
    check("fd_cs_high", 128'(cs), 128'(1));
    @(negedge clk);
    check("busy_fall", 128'(busy), 128'(0));
    check("cs_idle", 128'(cs), 128'(1));
    repeat (10) @(negedge clk);
    check("n_win", 128'(n_win), 128'(35));
    check("n_wv", 128'(n_wv), 128'(35));
    check("n_fd", 128'(n_fd), 128'(1));
    check("busy_cyc", 128'(busy_cyc), 128'(2380));
    check("n_wv1", 128'(n_wv1), 128'(35));

    // Continuous: two back-to-back frames, stray starts ignored
    n_win = 0; n_wv = 0; n_fd = 0; busy_cyc = 0; exp_idx = 0;
    continuous = 1'b1;
    pulse_start();
    wait_fd(3000);
    @(negedge clk);
    check("cont_busy", 128'(busy), 128'(1));
    check("cont_cs_low", 128'(cs), 128'(0));
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    continuous = 1'b0;
    wait_fd(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cont_end_busy", 128'(busy), 128'(0));
    check("cont_end_cs", 128'(cs), 128'(1));
    repeat (100) @(negedge clk);
    check("stay_idle", 128'(busy), 128'(0));
    check("cont_n_fd", 128'(n_fd), 128'(2));
    check("cont_n_win", 128'(n_win), 128'(70));
    check("cont_n_wv", 128'(n_wv), 128'(70));
    check("cont_busy_cyc", 128'(busy_cyc), 128'(4760));

    // Reset during SHIFT of command 10
    n_win = 0; n_wv = 0; n_fd = 0; exp_idx = 0;
    pulse_start();
    n = 0;
    while (n_win < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_cmd10", 128'(n_win), 128'(10));
    repeat (24) @(negedge clk);
    check("pre_rst_cs", 128'(cs), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs", 128'(cs), 128'(1));
    check("mid_rst_sclk", 128'(sclk), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_wv", 128'(word_valid), 128'(0));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("no_wv10", 128'(n_wv), 128'(10));
    check("post_rst_busy", 128'(busy), 128'(0));

    // Fresh frame after reset restarts at index 0
    n_win = 0; n_wv = 0; n_fd = 0; exp_idx = 0;
    pulse_start();
    wait_fd(3000);
    @(negedge clk);
    check("restart_n_wv", 128'(n_wv), 128'(35));
    check("restart_n_win", 128'(n_win), 128'(35));
    check("restart_n_fd", 128'(n_fd), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

endmodule
